// File: rtl/alu_pkg.sv
// Shared opcode encoding and latency constants for the alu block.
package alu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'd0,
    ADD_OP = 3'd1,
    AND_OP = 3'd2,
    XOR_OP = 3'd3,
    MUL_OP = 3'd4,
    RST_OP = 3'd7
  } alu_op_t;

  localparam int unsigned ALU_DATA_WIDTH = 8;
  localparam int unsigned ALU_SIMPLE_LAT = 1;

  // Shift-add multiply retires one operand bit per cycle.
  function automatic int unsigned alu_mul_lat(input int unsigned width);
    return width;
  endfunction

  localparam int unsigned ALU_MUL_LAT = alu_mul_lat(ALU_DATA_WIDTH);

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Bit 0 is folded in at the start edge; done flags the edge that completes the product.
module alu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [PROD_W-1:0]     acc;
  logic [PROD_W-1:0]     a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [CNT_W-1:0]      cnt;
  logic [PROD_W-1:0]     term;

  assign term    = b_sh[0] ? a_sh : '0;
  assign done    = busy && (cnt == LAST_BIT);
  assign product = acc + term;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (start) begin
      acc  <= b[0] ? PROD_W'(a) : '0;
      a_sh <= PROD_W'(a) << 1;
      b_sh <= b >> 1;
      cnt  <= CNT_W'(1);
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= acc + term;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu.sv
// Handshaked ALU: add/and/xor complete in one cycle, multiply is iterative.
// Result is registered and held between single-cycle done strobes.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  output logic                    ready,
  input  logic [2:0]              op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result
);

  // EXEC marks the cycle presenting a simple-op result; it accepts like IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t                  state;
  alu_op_t                 op_e;
  logic                    accept;
  logic                    mul_start;
  logic                    mul_busy;
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;
  logic [RESULT_WIDTH-1:0] simple_res;

  assign op_e      = alu_op_t'(op);
  assign accept    = valid && ready;
  assign mul_start = accept && (op_e == MUL_OP);

  always_comb begin
    simple_res = '0;
    case (op_e)
      ADD_OP:  simple_res = RESULT_WIDTH'(a) + RESULT_WIDTH'(b);
      AND_OP:  simple_res = RESULT_WIDTH'(a & b);
      XOR_OP:  simple_res = RESULT_WIDTH'(a ^ b);
      default: simple_res = '0;
    endcase
  end

  alu_mul_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, EXEC: begin
          ready <= 1'b1;
          state <= IDLE;
          if (accept) begin
            case (op_e)
              ADD_OP, AND_OP, XOR_OP: begin
                result <= simple_res;
                done   <= 1'b1;
                state  <= EXEC;
              end
              MUL_OP: begin
                ready <= 1'b0;
                state <= MUL;
              end
              RST_OP:  result <= '0;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (mul_done) begin
            result <= RESULT_WIDTH'(mul_product);
            done   <= 1'b1;
            ready  <= 1'b1;
            state  <= IDLE;
          end else if (!mul_busy) begin
            // Multiplier lost its operation; recover rather than stall forever.
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
